// File: rtl/cmd_stream_in.sv
// ---------------------------------------------------------------------------
// cmd_stream_in
//
// Byte-stream command receiver. It sits between the SPI byte receiver and the
// scratch memories. A command has three parts:
//   1. an opcode byte that selects the channel (1..NUM_CH);
//   2. a little-endian length field of LEN_BYTES bytes, counted in words;
//   3. a payload of len words, each WORD_BYTES bytes and little-endian.
// Each assembled word is written to the selected channel at word address
// 0, 1, 2 and so on. A length greater than 2**ADDR_W is rejected. The host can
// abort the current command at any time.
//
// Optional build macro:
//   CMD_CHECKSUM_EN - one checksum byte follows the payload. It is the XOR of
//                     the opcode, the length bytes and the payload bytes.
//                     cmd_done is delayed until that byte has been checked.
//                     A mismatch raises cmd_err in place of cmd_done.
//
// Ports:
//   clk        in   clock
//   rst_L      in   asynchronous active-low reset
//   byte_recv  in   received byte, qualified by valid
//   valid      in   one-cycle strobe per received byte
//   abort      in   abort of the current command; takes priority over valid
//   mem_we     out  one-cycle scratch write strobe
//   mem_ch     out  channel of the write (opcode-1)
//   mem_addr   out  word address within the channel region
//   mem_data   out  assembled word
//   cmd_ready  out  pulse: header accepted
//   cmd_ch     out  channel of the current command, held until the next header
//   cmd_len    out  word count of the current command, held
//   cmd_done   out  pulse: command completed
//   cmd_err    out  pulse: bad opcode, oversize length or checksum mismatch
//   busy       out  high while a command is being received
// ---------------------------------------------------------------------------
module cmd_stream_in #(
  parameter int WORD_BYTES = 4,
  parameter int ADDR_W     = 16,
  parameter int LEN_BYTES  = 4,
  parameter int NUM_CH     = 2,
  parameter int CH_W       = 1
) (
  input  logic                    clk,
  input  logic                    rst_L,
  input  logic [7:0]              byte_recv,
  input  logic                    valid,
  input  logic                    abort,
  output logic                    mem_we,
  output logic [CH_W-1:0]         mem_ch,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [8*WORD_BYTES-1:0] mem_data,
  output logic                    cmd_ready,
  output logic [CH_W-1:0]         cmd_ch,
  output logic [ADDR_W:0]         cmd_len,
  output logic                    cmd_done,
  output logic                    cmd_err,
  output logic                    busy
);

  localparam int                DW        = 8*WORD_BYTES;
  localparam int                LW        = 8*LEN_BYTES;
  localparam logic [2:0]        LEN_LAST  = 3'(LEN_BYTES-1);
  localparam logic [2:0]        WORD_LAST = 3'(WORD_BYTES-1);
  localparam logic [7:0]        MAX_OP    = 8'(NUM_CH);
  localparam logic [63:0]       MAX_LEN   = 64'd1 << ADDR_W;
  localparam logic [ADDR_W:0]   LEN_ONE   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] IDX_ONE   = ADDR_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_LEN, S_DATA, S_CKSUM} state_t;

  state_t            r_state;
  logic [CH_W-1:0]   r_ch;
  logic [2:0]        r_byte_cnt;
  logic [LW-1:0]     r_len_acc;
  logic [DW-1:0]     r_buf;
  logic [ADDR_W-1:0] r_word_idx;
`ifdef CMD_CHECKSUM_EN
  logic [7:0]        r_xor;
`endif

  logic [5:0]        w_shift;
  logic [LW-1:0]     w_len_full;
  logic [63:0]       w_len64;
  logic [DW-1:0]     w_word;
  logic              w_op_ok;
  logic              w_last_word;

  // The same byte counter serves both the length field and the word
  // assembly. The incoming byte is OR-ed in at its little-endian position,
  // so the value that includes the current byte is available in this cycle.
  always_comb begin
    w_shift     = {r_byte_cnt, 3'b000};
    w_len_full  = r_len_acc | (LW'(byte_recv) << w_shift);
    w_len64     = 64'(w_len_full);
    w_word      = r_buf | (DW'(byte_recv) << w_shift);
    w_op_ok     = (byte_recv != 8'd0) && (byte_recv <= MAX_OP);
    // cmd_len is never 0 in DATA. Comparing idx+1 against it avoids an
    // underflow and still matches len = 2**ADDR_W at index 2**ADDR_W-1.
    w_last_word = ({1'b0, r_word_idx} + LEN_ONE) == cmd_len;
  end

  assign busy = (r_state != S_IDLE);

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      r_state    <= S_IDLE;
      r_ch       <= '0;
      r_byte_cnt <= '0;
      r_len_acc  <= '0;
      r_buf      <= '0;
      r_word_idx <= '0;
`ifdef CMD_CHECKSUM_EN
      r_xor      <= '0;
`endif
      mem_we     <= 1'b0;
      mem_ch     <= '0;
      mem_addr   <= '0;
      mem_data   <= '0;
      cmd_ready  <= 1'b0;
      cmd_ch     <= '0;
      cmd_len    <= '0;
      cmd_done   <= 1'b0;
      cmd_err    <= 1'b0;
    end else begin
      mem_we    <= 1'b0;
      cmd_ready <= 1'b0;
      cmd_done  <= 1'b0;
      cmd_err   <= 1'b0;
      if (abort) begin
        // Drop the partial word and length. Words already written and the
        // cmd_ch/cmd_len summary are left as they are.
        r_state    <= S_IDLE;
        r_byte_cnt <= '0;
        r_len_acc  <= '0;
        r_buf      <= '0;
      end else if (valid) begin
`ifdef CMD_CHECKSUM_EN
        r_xor <= r_xor ^ byte_recv;
`endif
        case (r_state)
          S_IDLE: begin
            if (w_op_ok) begin
              r_ch       <= CH_W'(byte_recv - 8'd1);
              r_byte_cnt <= '0;
              r_len_acc  <= '0;
              r_state    <= S_LEN;
`ifdef CMD_CHECKSUM_EN
              r_xor      <= byte_recv;
`endif
            end else if (byte_recv != 8'd0) begin
              cmd_err <= 1'b1;
            end
          end
          S_LEN: begin
            if (r_byte_cnt == LEN_LAST) begin
              r_byte_cnt <= '0;
              r_len_acc  <= '0;
              if (w_len64 > MAX_LEN) begin
                cmd_err <= 1'b1;
                r_state <= S_IDLE;
              end else begin
                cmd_ready  <= 1'b1;
                cmd_ch     <= r_ch;
                cmd_len    <= w_len64[ADDR_W:0];
                r_word_idx <= '0;
                r_buf      <= '0;
                if (w_len64 == 64'd0) begin
`ifdef CMD_CHECKSUM_EN
                  r_state  <= S_CKSUM;
`else
                  cmd_done <= 1'b1;
                  r_state  <= S_IDLE;
`endif
                end else begin
                  r_state <= S_DATA;
                end
              end
            end else begin
              r_len_acc  <= w_len_full;
              r_byte_cnt <= r_byte_cnt + 3'd1;
            end
          end
          S_DATA: begin
            if (r_byte_cnt == WORD_LAST) begin
              mem_we     <= 1'b1;
              mem_ch     <= r_ch;
              mem_addr   <= r_word_idx;
              mem_data   <= w_word;
              r_buf      <= '0;
              r_byte_cnt <= '0;
              if (w_last_word) begin
`ifdef CMD_CHECKSUM_EN
                r_state  <= S_CKSUM;
`else
                cmd_done <= 1'b1;
                r_state  <= S_IDLE;
`endif
              end else begin
                r_word_idx <= r_word_idx + IDX_ONE;
              end
            end else begin
              r_buf      <= w_word;
              r_byte_cnt <= r_byte_cnt + 3'd1;
            end
          end
`ifdef CMD_CHECKSUM_EN
          S_CKSUM: begin
            if (byte_recv == r_xor) cmd_done <= 1'b1;
            else                    cmd_err  <= 1'b1;
            r_state <= S_IDLE;
          end
`endif
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cmd_stream_in.sv
// ---------------------------------------------------------------------------
// tb_cmd_stream_in
//
// Self-checking bench for cmd_stream_in. The DUT is built with ADDR_W=4, so
// the 2**ADDR_W length boundary is reachable in a short run.
//
// Three kinds of stimulus are used:
//   - a table of fixed vectors whose expected values are written by hand;
//   - hand-written corner sequences: valid gaps, the length boundary, abort
//     and a mid-command reset;
//   - randomised command streams.
// The sequences and the random streams are checked against a byte-level model.
// The model keeps the bytes of the current command in a queue. It derives the
// header, the words and the checksum from the queue position and the queue
// contents.
//
// The bench also builds with CMD_CHECKSUM_EN defined.
// ---------------------------------------------------------------------------
module tb_cmd_stream_in;
  localparam int WB = 4, AW = 4, LB = 4, NCH = 2, CHW = 1;
`ifdef CMD_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic          clk = 1'b0, rst_L = 1'b0, valid = 1'b0, abort = 1'b0;
  logic [7:0]    byte_recv = 8'd0;
  logic          mem_we, cmd_ready, cmd_done, cmd_err, busy;
  logic [CHW-1:0] mem_ch, cmd_ch;
  logic [AW-1:0] mem_addr;
  logic [8*WB-1:0] mem_data;
  logic [AW:0]   cmd_len;

  cmd_stream_in #(.WORD_BYTES(WB), .ADDR_W(AW), .LEN_BYTES(LB),
                  .NUM_CH(NCH), .CH_W(CHW)) dut (
    .clk(clk), .rst_L(rst_L), .byte_recv(byte_recv), .valid(valid),
    .abort(abort), .mem_we(mem_we), .mem_ch(mem_ch), .mem_addr(mem_addr),
    .mem_data(mem_data), .cmd_ready(cmd_ready), .cmd_ch(cmd_ch),
    .cmd_len(cmd_len), .cmd_done(cmd_done), .cmd_err(cmd_err), .busy(busy));

  always #5 clk = ~clk;

  int n_vec = 0, n_miss = 0, n_we_seen = 0;

  // ---------------- reference model ----------------
  logic [7:0]  q[$];
  longint      m_len = 0;
  logic        e_we, e_rdy, e_done, e_err;
  longint      e_ch = 0, e_addr = 0, e_cch = 0, e_clen = 0;
  logic [31:0] e_data = 0;

  task automatic model_reset();
    q.delete();
    m_len = 0; e_we = 0; e_rdy = 0; e_done = 0; e_err = 0;
    e_ch = 0; e_addr = 0; e_cch = 0; e_clen = 0; e_data = 0;
  endtask

  task automatic model_step(input logic v, input logic [7:0] b, input logic ab);
    int n, hdr;
    longint pay;
    logic [7:0] x;
    e_we = 0; e_rdy = 0; e_done = 0; e_err = 0;
    hdr = 1 + LB;
    if (ab) q.delete();
    else if (v) begin
      if (q.size() == 0) begin
        if (b >= 1 && b <= NCH) q.push_back(b);
        else if (b != 0) e_err = 1;
      end else begin
        q.push_back(b);
        n = q.size();
        if (n == hdr) begin
          m_len = 0;
          for (int i = 1; i <= LB; i++) m_len |= longint'(q[i]) << (8*(i-1));
          if (m_len > (longint'(1) << AW)) begin
            e_err = 1; q.delete();
          end else begin
            e_rdy = 1; e_cch = longint'(q[0]) - 1; e_clen = m_len;
            if (m_len == 0 && !CK) begin e_done = 1; q.delete(); end
          end
        end else if (n > hdr) begin
          pay = longint'(n - hdr);
          if (pay <= m_len*WB) begin
            if (pay % WB == 0) begin
              e_we = 1; e_ch = longint'(q[0]) - 1; e_addr = pay/WB - 1;
              e_data = 0;
              for (int k = 0; k < WB; k++) e_data |= 32'(q[n-WB+k]) << (8*k);
              if (pay == m_len*WB && !CK) begin e_done = 1; q.delete(); end
            end
          end else begin
            x = 0;
            for (int i = 0; i < n-1; i++) x ^= q[i];
            if (x == q[n-1]) e_done = 1; else e_err = 1;
            q.delete();
          end
        end
      end
    end
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    n_vec++;
    chk({tag, ".mem_we"}, 64'(mem_we), 0);     chk({tag, ".mem_ch"}, 64'(mem_ch), 0);
    chk({tag, ".mem_addr"}, 64'(mem_addr), 0); chk({tag, ".mem_data"}, 64'(mem_data), 0);
    chk({tag, ".cmd_ready"}, 64'(cmd_ready), 0); chk({tag, ".cmd_ch"}, 64'(cmd_ch), 0);
    chk({tag, ".cmd_len"}, 64'(cmd_len), 0);   chk({tag, ".cmd_done"}, 64'(cmd_done), 0);
    chk({tag, ".cmd_err"}, 64'(cmd_err), 0);   chk({tag, ".busy"}, 64'(busy), 0);
  endtask

  // One clock with the given inputs, compared against the model.
  task automatic step(input logic v, input logic [7:0] b, input logic ab);
    valid = v; byte_recv = b; abort = ab;
    model_step(v, b, ab);
    @(posedge clk); #1;
    n_vec++;
    if (mem_we) n_we_seen++;
    chk("mem_we", 64'(mem_we), 64'(e_we));
    chk("cmd_ready", 64'(cmd_ready), 64'(e_rdy));
    chk("cmd_done", 64'(cmd_done), 64'(e_done));
    chk("cmd_err", 64'(cmd_err), 64'(e_err));
    chk("busy", 64'(busy), 64'(q.size() != 0));
    chk("mem_ch", 64'(mem_ch), 64'(e_ch));
    chk("mem_addr", 64'(mem_addr), 64'(e_addr));
    chk("mem_data", 64'(mem_data), 64'(e_data));
    chk("cmd_ch", 64'(cmd_ch), 64'(e_cch));
    chk("cmd_len", 64'(cmd_len), 64'(e_clen));
    valid = 0; abort = 0;
  endtask

  // Sends one command. nwords payload words follow the length field, and a
  // checksum byte follows when checksums are enabled. An abort is raised on
  // byte index abort_at (-1 for none). Idle gaps of gmin..gmax cycles are
  // placed after each byte.
  task automatic send_cmd(input int op, input longint lenf, input int nwords,
                          input bit ck_good, input int abort_at,
                          input int gmin, input int gmax);
    logic [7:0] bl[$];
    logic [7:0] x;
    bl.push_back(8'(op));
    for (int i = 0; i < LB; i++) bl.push_back(8'(lenf >> (8*i)));
    for (int i = 0; i < nwords*WB; i++) bl.push_back(8'($urandom_range(0, 255)));
    if (CK) begin
      x = 0;
      foreach (bl[i]) x ^= bl[i];
      bl.push_back(ck_good ? x : (x ^ 8'h5A));
    end
    foreach (bl[i]) begin
      if (i == abort_at) begin
        step(1'b1, bl[i], 1'b1);
        return;
      end
      step(1'b1, bl[i], 1'b0);
      repeat ($urandom_range(gmax, gmin)) step(1'b0, 8'($urandom), 1'b0);
    end
  endtask

  // ---------------- table-driven vectors ----------------
  typedef struct {
    logic v; logic [7:0] b; logic ab;
    logic we, rdy, done, err, bsy;
    logic [CHW-1:0] cch; logic [AW:0] clen; logic [AW-1:0] addr; logic [31:0] data;
  } tv_t;
  tv_t tv[$];

  task automatic add(input logic v, input logic [7:0] b, input logic ab,
                     input logic we, input logic rdy, input logic done,
                     input logic err, input logic bsy, input int cch,
                     input int clen, input int addr, input logic [31:0] data);
    tv_t r;
    r.v = v; r.b = b; r.ab = ab; r.we = we; r.rdy = rdy; r.done = done;
    r.err = err; r.bsy = bsy; r.cch = CHW'(cch); r.clen = (AW+1)'(clen);
    r.addr = AW'(addr); r.data = data;
    tv.push_back(r);
  endtask

  task automatic apply_tv(input tv_t r, input int idx);
    string nm;
    valid = r.v; byte_recv = r.b; abort = r.ab;
    model_step(r.v, r.b, r.ab);
    @(posedge clk); #1;
    n_vec++;
    if (mem_we) n_we_seen++;
    nm = $sformatf("tv%0d", idx);
    chk({nm, ".mem_we"}, 64'(mem_we), 64'(r.we));
    chk({nm, ".cmd_ready"}, 64'(cmd_ready), 64'(r.rdy));
    chk({nm, ".cmd_done"}, 64'(cmd_done), 64'(r.done));
    chk({nm, ".cmd_err"}, 64'(cmd_err), 64'(r.err));
    chk({nm, ".busy"}, 64'(busy), 64'(r.bsy));
    chk({nm, ".cmd_ch"}, 64'(cmd_ch), 64'(r.cch));
    chk({nm, ".cmd_len"}, 64'(cmd_len), 64'(r.clen));
    chk({nm, ".mem_addr"}, 64'(mem_addr), 64'(r.addr));
    chk({nm, ".mem_data"}, 64'(mem_data), 64'(r.data));
    valid = 0; abort = 0;
  endtask

  initial begin
    int w0;
    int op, nw, ab_at;
    longint lenf;
    model_reset();

    // Table: filler, bad opcode, a two-word command on channel 0, an idle
    // cycle carrying a junk byte, a zero-length command on channel 1, and an
    // abort raised together with a valid byte.
    add(1, 8'h00, 0, 0,0,0,0,0, 0,0,0, 32'h0);
    add(1, 8'h05, 0, 0,0,0,1,0, 0,0,0, 32'h0);
    add(1, 8'h01, 0, 0,0,0,0,1, 0,0,0, 32'h0);
    add(1, 8'h02, 0, 0,0,0,0,1, 0,0,0, 32'h0);
    add(1, 8'h00, 0, 0,0,0,0,1, 0,0,0, 32'h0);
    add(1, 8'h00, 0, 0,0,0,0,1, 0,0,0, 32'h0);
    add(1, 8'h00, 0, 0,1,0,0,1, 0,2,0, 32'h0);
    add(1, 8'hAA, 0, 0,0,0,0,1, 0,2,0, 32'h0);
    add(1, 8'hBB, 0, 0,0,0,0,1, 0,2,0, 32'h0);
    add(1, 8'hCC, 0, 0,0,0,0,1, 0,2,0, 32'h0);
    add(1, 8'hDD, 0, 1,0,0,0,1, 0,2,0, 32'hDDCCBBAA);
    add(0, 8'h77, 0, 0,0,0,0,1, 0,2,0, 32'hDDCCBBAA);
    add(1, 8'h11, 0, 0,0,0,0,1, 0,2,0, 32'hDDCCBBAA);
    add(1, 8'h22, 0, 0,0,0,0,1, 0,2,0, 32'hDDCCBBAA);
    add(1, 8'h33, 0, 0,0,0,0,1, 0,2,0, 32'hDDCCBBAA);
    add(1, 8'h44, 0, 1,0,!CK,0,CK, 0,2,1, 32'h44332211);
    if (CK) add(1, 8'h47, 0, 0,0,1,0,0, 0,2,1, 32'h44332211);
    add(1, 8'h02, 0, 0,0,0,0,1, 0,2,1, 32'h44332211);
    add(1, 8'h00, 0, 0,0,0,0,1, 0,2,1, 32'h44332211);
    add(1, 8'h00, 0, 0,0,0,0,1, 0,2,1, 32'h44332211);
    add(1, 8'h00, 0, 0,0,0,0,1, 0,2,1, 32'h44332211);
    add(1, 8'h00, 0, 0,1,!CK,0,CK, 1,0,1, 32'h44332211);
    if (CK) add(1, 8'h02, 0, 0,0,1,0,0, 1,0,1, 32'h44332211);
    add(1, 8'h02, 1, 0,0,0,0,0, 1,0,1, 32'h44332211);

    // Reset state
    #12;
    chk_zero("reset");
    @(negedge clk); rst_L = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < tv.size(); i++) apply_tv(tv[i], i);

    // Opcode 2, one word, three idle cycles between bytes
    w0 = n_we_seen;
    send_cmd(2, 1, 1, 1'b1, -1, 3, 3);
    repeat (2) step(1'b0, 8'h00, 1'b0);
    n_vec++; chk("gap_writes", 64'(n_we_seen - w0), 1);

    // Length boundary: 17 words is rejected, 16 words ends at address 15
    w0 = n_we_seen;
    send_cmd(1, 17, 0, 1'b1, -1, 0, 0);
    step(1'b0, 8'h00, 1'b0);
    n_vec++; chk("oversize_writes", 64'(n_we_seen - w0), 0);
    w0 = n_we_seen;
    send_cmd(1, 16, 16, 1'b1, -1, 0, 0);
    step(1'b0, 8'h00, 1'b0);
    n_vec++; chk("max_len_writes", 64'(n_we_seen - w0), 16);
    n_vec++; chk("max_len_last_addr", 64'(mem_addr), 15);

    // Abort during word 1 of a three-word command, then a clean new command
    w0 = n_we_seen;
    send_cmd(1, 3, 3, 1'b1, 1 + LB + WB + 2, 0, 0);
    step(1'b0, 8'h00, 1'b0);
    n_vec++; chk("abort_writes", 64'(n_we_seen - w0), 1);
    n_vec++; chk("abort_busy", 64'(busy), 0);
    send_cmd(1, 1, 1, 1'b1, -1, 0, 1);
    step(1'b0, 8'h00, 1'b0);
    n_vec++; chk("after_abort_addr", 64'(mem_addr), 0);

    // Bad checksum byte (a plain one-word command without checksums)
    send_cmd(2, 1, 1, 1'b0, -1, 0, 0);
    step(1'b0, 8'h00, 1'b0);

    // Randomised command streams
    for (int it = 0; it < 60; it++) begin
      op   = ($urandom_range(0, 9) < 7) ? int'($urandom_range(1, NCH)) : int'($urandom_range(0, 4));
      lenf = longint'($urandom_range(0, 17));
      if ($urandom_range(0, 7) == 0) lenf |= longint'(1) << (8*$urandom_range(1, LB-1));
      nw    = (lenf <= 16) ? int'(lenf) : 0;
      ab_at = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 1 + LB + nw*WB)) : -1;
      send_cmd(op, lenf, nw, $urandom_range(0, 3) != 0, ab_at, 0, 2);
      if (q.size() != 0) step(1'b0, 8'h00, 1'b1);
      step(1'b0, 8'h00, 1'b0);
    end

    // Reset in the middle of a command
    send_cmd(2, 2, 1, 1'b1, -1, 0, 0);
    #2 rst_L = 1'b0;
    #2;
    model_reset();
    chk_zero("midreset");
    @(negedge clk); rst_L = 1'b1;
    send_cmd(2, 1, 1, 1'b1, -1, 0, 0);
    step(1'b0, 8'h00, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
